// File: rtl/mux_pkg.sv
// mux_pkg: shared state encodings and default hold length for the mux stimulus generator
package mux_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FINISH = 2'd2} state_t;
  localparam int HOLD_DEFAULT = 10;
endpackage

// File: rtl/mux_ref.sv
// mux_ref: combinational golden 2:1 mux used to judge the returned y
module mux_ref (
  input  logic a,
  input  logic b,
  input  logic s0,
  output logic expected
);
  assign expected = s0 ? b : a;
endmodule

// File: rtl/mux_stim_gen.sv
// mux_stim_gen: sweeps all 8 {a,b,s0} vectors into a 2:1 mux and counts wrong y samples
module mux_stim_gen
  import mux_pkg::*;
#(
  parameter int HOLD = HOLD_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       a,
  output logic       b,
  output logic       s0,
  input  logic       y,
  output logic       busy,
  output logic       done,
  output logic [3:0] err_cnt,
  output logic       pass
);
  state_t     state;
  logic [7:0] cnt;
  logic [2:0] idx;
  logic       exp_y, wrap, mis;
  logic [3:0] err_nxt;
  mux_ref u_ref (.a(a), .b(b), .s0(s0), .expected(exp_y));
  assign wrap    = cnt == 8'(HOLD - 1);
  assign mis     = wrap && (y != exp_y);
  assign err_nxt = err_cnt + {3'd0, mis};
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state   <= IDLE;
      cnt     <= 8'd0;
      idx     <= 3'd0;
      {a, b, s0} <= 3'd0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err_cnt <= 4'd0;
      pass    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state   <= RUN;
          busy    <= 1'b1;
          err_cnt <= 4'd0;
          pass    <= 1'b0;
          idx     <= 3'd0;
          cnt     <= 8'd0;
          {a, b, s0} <= 3'd0;
        end
        RUN: begin
          err_cnt <= err_nxt;
          if (!wrap) cnt <= cnt + 8'd1;
          else if (idx == 3'd7) begin
            state <= FINISH;
            done  <= 1'b1;
            pass  <= err_nxt == 4'd0;
            cnt   <= 8'd0;
            idx   <= 3'd0;
            {a, b, s0} <= 3'd0;
          end else begin
            cnt <= 8'd0;
            idx <= idx + 3'd1;
            {a, b, s0} <= idx + 3'd1;
          end
        end
        default: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
endmodule

// File: tb/tb_mux_stim_gen.sv
// tb_mux_stim_gen: timeline model of the sweep plus literal checks of the key scenarios
module tb_mux_stim_gen;
  localparam int H = 2;
  logic clk = 0, rst = 1, start = 0;
  logic a, b, s0, y, busy, done, pass;
  logic [3:0] err_cnt;
  int mode = 0;
  logic [7:0] flip = 0;
  int nvec = 0, nmis = 0, ndone = 0;
  int k = -1, merr = 0;
  bit mpass = 0;
  logic m;

  always #5 clk = ~clk;

  mux_stim_gen #(.HOLD(H)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .s0(s0), .y(y),
    .busy(busy), .done(done), .err_cnt(err_cnt), .pass(pass)
  );

  // y modes: 0 correct mux, 1 tied low, 2 inverted, 3 correct with random per-vector flips
  assign m = s0 ? b : a;
  assign y = mode == 1 ? 1'b0 : mode == 2 ? ~m : mode == 3 ? m ^ flip[{a, b, s0}] : m;

  function automatic bit mism(input logic [2:0] v);
    logic good;
    good = v[0] ? v[1] : v[2];
    return mode == 1 ? good : mode == 2 ? 1'b1 : mode == 3 ? flip[v] : 1'b0;
  endfunction

  // k = edges since the start edge; vector v is sampled at edge (v+1)*H, FINISH at 8*H
  always @(posedge clk or posedge rst)
    if (rst) begin
      k = -1; merr = 0; mpass = 0;
    end else if (k < 0) begin
      if (start) begin k = 0; merr = 0; mpass = 0; end
    end else if (k == 8 * H) k = -1;
    else begin
      k++;
      if (k % H == 0 && mism(3'(k / H - 1))) merr++;
      if (k == 8 * H) mpass = merr == 0;
    end

  always @(negedge clk) begin
    logic [2:0] ev;
    logic [9:0] e, act;
    ev  = (k >= 0 && k < 8 * H) ? 3'(k / H) : 3'd0;
    e   = {ev, k >= 0, k == 8 * H, 4'(merr), mpass};
    act = {a, b, s0, busy, done, err_cnt, pass};
    nvec++;
    if (act !== e) begin
      nmis++;
      $display("FAIL cycle t=%0t {abs,busy,done,err,pass}: got %b want %b", $time, act, e);
    end
    if (done) ndone++;
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string n, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nmis++;
      $display("FAIL %s: got %0d want %0d", n, act, exp);
    end
  endtask

  task automatic wait_done(output int n);
    n = 0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (done) begin n = i; return; end
    end
  endtask

  task automatic sweep(input int md, output int lat);
    mode = md;
    start = 1;
    tick;
    start = 0;
    wait_done(lat);
    tick;
  endtask

  initial begin
    int lat, d0, l1, l2;
    repeat (3) tick;
    chk("reset_state", {a, b, s0, busy, done, err_cnt, pass}, 0);
    rst = 0;
    tick;
    d0 = ndone;
    sweep(0, lat);
    chk("good_latency", lat, 17);
    chk("good_err", err_cnt, 0);
    chk("good_pass", pass, 1);
    chk("good_ndone", ndone - d0, 1);
    sweep(1, lat);
    chk("y0_err", err_cnt, 4);
    chk("y0_pass", pass, 0);
    sweep(2, lat);
    chk("inv_err", err_cnt, 8);
    chk("inv_pass", pass, 0);
    mode = 0;
    d0 = ndone;
    start = 1;
    tick;
    start = 0;
    repeat (3 * H) tick;
    start = 1;
    tick;
    start = 0;
    wait_done(lat);
    chk("restart_done_seen", lat > 0, 1);
    repeat (4) tick;
    chk("restart_ndone", ndone - d0, 1);
    chk("restart_err", err_cnt, 0);
    mode = 2;
    d0 = ndone;
    start = 1;
    tick;
    start = 0;
    repeat (5 * H) tick;
    chk("pre_rst_vec", {a, b, s0}, 5);
    rst = 1;
    #1;
    chk("mid_rst_zero", {a, b, s0, busy, done, err_cnt, pass}, 0);
    tick;
    rst = 0;
    repeat (2 * 8 * H) tick;
    chk("rst_no_done", ndone - d0, 0);
    sweep(0, lat);
    chk("post_rst_latency", lat, 17);
    chk("post_rst_err", err_cnt, 0);
    chk("post_rst_pass", pass, 1);
    mode = 1;
    start = 1;
    wait_done(l1);
    chk("held_first_latency", l1, 18);
    chk("held_first_err", err_cnt, 4);
    tick;
    chk("held_idle_busy", busy, 0);
    tick;
    chk("held_restart_busy", busy, 1);
    chk("held_restart_err", err_cnt, 0);
    wait_done(l2);
    chk("held_second_latency", l2, 17);
    start = 0;
    tick;
    chk("held_second_err", err_cnt, 4);
    chk("held_second_pass", pass, 0);
    repeat (6) begin
      repeat ($urandom_range(0, 3)) tick;
      flip = 8'($urandom);
      sweep(3, lat);
      chk("rand_err", err_cnt, $countones(flip));
      chk("rand_pass", pass, flip == 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
